// File: rtl/multi_trigger_gen_pkg.sv
// Shared definitions for the multi-channel trigger generator: channel FSM
// states and the counter-width helper.
package multi_trigger_gen_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_READY  = 2'd1,
        PULSE       = 2'd2,
        WAIT_PERIOD = 2'd3
    } ch_state_t;

    // Bits needed to hold 0..n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multi_trigger_gen_us_tick.sv
// Microsecond prescaler: us_tick is high for one cycle out of every CLK_MHZ.
module us_tick_gen #(
    parameter int CLK_MHZ = 24
) (
    input  logic clk,
    input  logic rst_n,
    output logic us_tick
);
    localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_MHZ - 1);

    logic [PW-1:0] presc;

    assign us_tick = (presc == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       presc <= '0;
        else if (us_tick) presc <= '0;
        else              presc <= presc + 1'b1;
    end
endmodule

// File: rtl/multi_trigger_gen.sv
// N-channel periodic active-low trigger generator with per-channel ready
// gating, burst/continuous modes, missed-slot and burst-done flags.
module multi_trigger_gen
    import multi_trigger_gen_pkg::*;
#(
    parameter int CLK_MHZ     = 24,
    parameter int N_CH        = 2,
    parameter int T_US_INT    = 25000,
    parameter int T_US_TRIG   = 50,
    parameter int BURST_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [N_CH-1:0]    bin_n,
    input  logic [N_CH-1:0]    busy,
    output logic [N_CH-1:0]    trig_n,
    output logic [N_CH-1:0]    missed,
    output logic [N_CH-1:0]    done,
    output logic [N_CH-1:0]    active
);
    localparam int PCW = cnt_w(T_US_INT);
    localparam int WCW = cnt_w(T_US_TRIG);

    generate
        if (T_US_INT <= T_US_TRIG || CLK_MHZ < 1 || T_US_TRIG < 1 || SYNC_STAGES < 1) begin : g_bad_cfg
            $error("multi_trigger_gen: invalid timing parameters");
        end
    endgenerate

    // Async assert, synchronous release.
    logic [1:0] rst_sync;
    logic       rst_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_s = rst_sync[1];

    logic us_tick;

    us_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
        .clk     (clk),
        .rst_n   (rst_s),
        .us_tick (us_tick)
    );

    // Idle levels of the pins (bin_n pulled up, busy pulled down) are the reset values.
    logic [SYNC_STAGES-1:0][N_CH-1:0] bin_sync, busy_sync;
    logic [N_CH-1:0]                  can_trig;

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            bin_sync  <= '1;
            busy_sync <= '0;
        end else begin
            bin_sync[0]  <= bin_n;
            busy_sync[0] <= busy;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                bin_sync[s]  <= bin_sync[s-1];
                busy_sync[s] <= busy_sync[s-1];
            end
        end
    end
    assign can_trig = ~bin_sync[SYNC_STAGES-1] & ~busy_sync[SYNC_STAGES-1];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t          state, state_nx;
        logic [PCW-1:0]     pcnt, pcnt_nx;
        logic [WCW-1:0]     wcnt, wcnt_nx;
        logic [BURST_W-1:0] fired, fired_nx, target, target_nx, fired_inc;
        logic               trig_r, trig_nx, missed_r, missed_nx, done_r, done_nx;

        assign fired_inc = (&fired) ? fired : fired + 1'b1;

        always_ff @(posedge clk or negedge rst_s) begin
            if (!rst_s) begin
                state    <= IDLE;
                pcnt     <= '0;
                wcnt     <= '0;
                fired    <= '0;
                target   <= '0;
                trig_r   <= 1'b1;
                missed_r <= 1'b0;
                done_r   <= 1'b0;
            end else begin
                state    <= state_nx;
                pcnt     <= pcnt_nx;
                wcnt     <= wcnt_nx;
                fired    <= fired_nx;
                target   <= target_nx;
                trig_r   <= trig_nx;
                missed_r <= missed_nx;
                done_r   <= done_nx;
            end
        end

        // pcnt runs from each falling edge, so the period is measured start-to-start.
        always_comb begin
            state_nx  = state;
            pcnt_nx   = pcnt;
            wcnt_nx   = wcnt;
            fired_nx  = fired;
            target_nx = target;
            trig_nx   = trig_r;
            missed_nx = 1'b0;
            done_nx   = 1'b0;
            case (state)
                IDLE: if (start && en) begin
                    state_nx  = WAIT_READY;
                    target_nx = burst_len;
                    fired_nx  = '0;
                end
                WAIT_READY: if (us_tick) begin
                    if (!en) begin
                        state_nx = IDLE;
                    end else if (can_trig[i]) begin
                        state_nx = PULSE;
                        trig_nx  = 1'b0;
                        pcnt_nx  = '0;
                        wcnt_nx  = '0;
                    end
                end
                PULSE: if (us_tick) begin
                    pcnt_nx = pcnt + 1'b1;
                    wcnt_nx = wcnt + 1'b1;
                    if (wcnt == WCW'(T_US_TRIG - 1)) begin
                        trig_nx  = 1'b1;
                        fired_nx = fired_inc;
                        if (target != '0 && fired_inc == target) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end else if (!en) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx = WAIT_PERIOD;
                        end
                    end
                end
                WAIT_PERIOD: if (us_tick) begin
                    pcnt_nx = pcnt + 1'b1;
                    if (!en) begin
                        state_nx = IDLE;
                    end else if (pcnt == PCW'(T_US_INT - 1)) begin
                        if (can_trig[i]) begin
                            state_nx = PULSE;
                            trig_nx  = 1'b0;
                            pcnt_nx  = '0;
                            wcnt_nx  = '0;
                        end else begin
                            state_nx  = WAIT_READY;
                            missed_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        assign trig_n[i] = trig_r;
        assign missed[i] = missed_r;
        assign done[i]   = done_r;
        assign active[i] = (state != IDLE);
    end
endmodule
